// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

   // Controller phases: waiting for a request, shifting bits, holding result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sumador_comp.sv
// Single-bit full-adder cell; the one arithmetic element the sequencer reuses.
module sumador_comp (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder time-shared LSB-first over WIDTH cycles,
// with valid/ready handshakes on both the request and the result side.
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             fa_sum, fa_cout;
   logic             accept;

   // The only arithmetic: current LSBs plus the carry kept from the previous bit.
   sumador_comp u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign accept = start_valid && (state == IDLE);

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
   // Written as shift-then-overwrite so WIDTH=1 needs no special case.
   always_comb begin
      res_nx            = res_sh >> 1;
      res_nx[WIDTH-1]   = fa_sum;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; DONE->IDLE never accepts in the same cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_valid)     state_nx = RUN;
         RUN:     if (cnt == LAST_BIT) state_nx = DONE;
         DONE:    if (res_ready)       state_nx = IDLE;
         default:                      state_nx = IDLE;
      endcase
   end

   // Operand/result shifters, carry flop and bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh   <= op_a;
         b_sh   <= op_b;
         res_sh <= '0;
         carry  <= cin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= res_nx;
         carry  <= fa_cout;
         cnt    <= cnt + 1'b1;
      end
   end

   assign start_ready = (state == IDLE);
   assign res_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign sum         = res_sh;
   assign cout        = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances
// compared against plain integer addition.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         start_valid, start_ready, cin, res_valid, res_ready, cout, busy;
   logic [W-1:0] op_a, op_b, sum;

   logic d1_start_valid, d1_start_ready, d1_cin, d1_res_valid, d1_res_ready, d1_cout, d1_busy;
   logic [0:0] d1_op_a, d1_op_b, d1_sum;

   int checks = 0;
   int errors = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .op_a(op_a), .op_b(op_b), .cin(cin),
      .res_valid(res_valid), .res_ready(res_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst),
      .start_valid(d1_start_valid), .start_ready(d1_start_ready),
      .op_a(d1_op_a), .op_b(d1_op_b), .cin(d1_cin),
      .res_valid(d1_res_valid), .res_ready(d1_res_ready),
      .sum(d1_sum), .cout(d1_cout), .busy(d1_busy)
   );

   // Reference: exact unsigned addition, carry in the top bit.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] r;
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request with res_ready held high; report result and latency
   // (cycles from accept edge to res_valid, -1 on timeout).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] s, output logic co, output int lat);
      start_valid = 1'b1; op_a = a; op_b = b; cin = c; res_ready = 1'b1;
      tick();
      start_valid = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (res_valid) begin lat = i; break; end
      end
      s = sum; co = cout;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks += 5;
      if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b exp 1", start_ready); end
      if (res_valid !== 1'b0)   begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
      if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (sum !== '0)           begin errors++; $display("FAIL reset_sum got %h exp 00", sum); end
      if (cout !== 1'b0)        begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [4] = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
      logic [W-1:0] vb [4] = '{8'h3C, 8'h01, 8'hFF, 8'h00};
      logic         vc [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
      logic [W-1:0] es [4] = '{8'h96, 8'h00, 8'hFF, 8'h01};
      logic         ec [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
      logic [W-1:0] s; logic co; int lat;
      for (int k = 0; k < 4; k++) begin
         run_op(va[k], vb[k], vc[k], s, co, lat);
         checks += 4;
         if (lat !== W)  begin errors++; $display("FAIL directed%0d_latency got %0d exp %0d", k, lat, W); end
         if (s !== es[k]) begin errors++; $display("FAIL directed%0d_sum got %h exp %h", k, s, es[k]); end
         if (co !== ec[k]) begin errors++; $display("FAIL directed%0d_cout got %b exp %b", k, co, ec[k]); end
         if (start_ready !== 1'b1) begin errors++; $display("FAIL directed%0d_idle_after got %b exp 1", k, start_ready); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, s; logic c, co; logic [W:0] e; int lat;
      for (int k = 0; k < 24; k++) begin
         a = W'($urandom); b = W'($urandom); c = 1'($urandom);
         e = ref_add(a, b, c);
         run_op(a, b, c, s, co, lat);
         checks += 2;
         if ({co, s} !== e) begin errors++; $display("FAIL random%0d_result %h+%h+%b got %b_%h exp %b_%h", k, a, b, c, co, s, e[W], e[W-1:0]); end
         if (lat !== W)     begin errors++; $display("FAIL random%0d_latency got %0d exp %0d", k, lat, W); end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a, b; logic c; logic [W:0] e; int lat;
      a = W'($urandom); b = W'($urandom); c = 1'b1;
      e = ref_add(a, b, c);
      start_valid = 1'b1; op_a = a; op_b = b; cin = c; res_ready = 1'b0;
      tick();
      start_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (res_valid) begin lat = i; break; end
      end
      checks++;
      if (lat !== W) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, W); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks += 3;
         if (res_valid !== 1'b1)  begin errors++; $display("FAIL bp_hold%0d_res_valid got %b exp 1", i, res_valid); end
         if ({cout, sum} !== e)   begin errors++; $display("FAIL bp_hold%0d_result got %b_%h exp %b_%h", i, cout, sum, e[W], e[W-1:0]); end
         if (start_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_start_ready got %b exp 0", i, start_ready); end
      end
      res_ready = 1'b1;
      tick();
      checks += 2;
      if (start_ready !== 1'b1) begin errors++; $display("FAIL bp_release_start_ready got %b exp 1", start_ready); end
      if (res_valid !== 1'b0)   begin errors++; $display("FAIL bp_release_res_valid got %b exp 0", res_valid); end
   endtask

   task automatic test_busy_reject();
      logic [W-1:0] a, b; logic c; logic [W:0] e; int nvalid;
      a = 8'h2C; b = 8'hE7; c = 1'b0;
      e = ref_add(a, b, c);
      start_valid = 1'b1; op_a = a; op_b = b; cin = c; res_ready = 1'b1;
      tick();
      start_valid = 1'b0;
      tick(); tick();
      start_valid = 1'b1; op_a = 8'h11; op_b = 8'h11; cin = 1'b1;
      checks++;
      if (start_ready !== 1'b0) begin errors++; $display("FAIL reject_start_ready got %b exp 0", start_ready); end
      tick();
      start_valid = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 2 * W + 4; i++) begin
         if (res_valid) begin
            nvalid++;
            checks++;
            if ({cout, sum} !== e) begin errors++; $display("FAIL reject_result got %b_%h exp %b_%h", cout, sum, e[W], e[W-1:0]); end
         end
         tick();
      end
      checks++;
      if (nvalid !== 1) begin errors++; $display("FAIL reject_valid_count got %0d exp 1", nvalid); end
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] s; logic co; int lat, nvalid;
      start_valid = 1'b1; op_a = 8'hC3; op_b = 8'h5E; cin = 1'b1; res_ready = 1'b1;
      tick();
      start_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks += 4;
      if (start_ready !== 1'b1) begin errors++; $display("FAIL midrst_start_ready got %b exp 1", start_ready); end
      if (res_valid !== 1'b0)   begin errors++; $display("FAIL midrst_res_valid got %b exp 0", res_valid); end
      if (busy !== 1'b0)        begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
      if (sum !== '0)           begin errors++; $display("FAIL midrst_sum got %h exp 00", sum); end
      nvalid = 0;
      for (int i = 0; i < W + 2; i++) begin
         if (res_valid) nvalid++;
         tick();
      end
      checks++;
      if (nvalid !== 0) begin errors++; $display("FAIL midrst_ghost_valid got %0d exp 0", nvalid); end
      run_op(8'h01, 8'h02, 1'b0, s, co, lat);
      checks += 2;
      if ({co, s} !== 9'h003) begin errors++; $display("FAIL midrst_followup got %b_%h exp 0_03", co, s); end
      if (lat !== W)          begin errors++; $display("FAIL midrst_followup_latency got %0d exp %0d", lat, W); end
   endtask

   task automatic test_width1();
      logic a, b, c; logic [1:0] e;
      for (int v = 0; v < 8; v++) begin
         c = v[2]; a = v[1]; b = v[0];
         e = {1'b0, a} + {1'b0, b} + {1'b0, c};
         d1_start_valid = 1'b1; d1_op_a = a; d1_op_b = b; d1_cin = c; d1_res_ready = 1'b1;
         tick();
         d1_start_valid = 1'b0; d1_op_a = ~a; d1_op_b = ~b; d1_cin = ~c;
         tick();
         checks += 2;
         if (d1_res_valid !== 1'b1)        begin errors++; $display("FAIL w1_case%0d_latency res_valid got %b exp 1", v, d1_res_valid); end
         if ({d1_cout, d1_sum} !== e)      begin errors++; $display("FAIL w1_case%0d_result got %b%b exp %b", v, d1_cout, d1_sum, e); end
         tick();
         checks++;
         if (d1_start_ready !== 1'b1) begin errors++; $display("FAIL w1_case%0d_idle got %b exp 1", v, d1_start_ready); end
      end
   endtask

   initial begin
      rst = 1'b1;
      start_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; res_ready = 1'b0;
      d1_start_valid = 1'b0; d1_op_a = '0; d1_op_b = '0; d1_cin = 1'b0; d1_res_ready = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_busy_reject();
      test_reset_mid_run();
      test_width1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder sequencer built around the team's single full-adder cell. It accepts a WIDTH-bit addition request through a valid/ready handshake. It then pushes the operands LSB-first through one full adder over WIDTH cycles, holding the carry in a flop between bits. The result is returned through a second valid/ready handshake. It is the controller that time-shares one full adder across all bit positions of a multi-bit add.

## Interface
- Reset: one clock; reset is synchronous and active-high.
- Parameters:
  - WIDTH, default 8: operand/result width in bits; legal range ≥ 1.
- Ports:
  - clk, input, 1: rising-edge clock.
  - rst, input, 1: synchronous active-high reset.
  - start_valid, input, 1: request present.
  - start_ready, output, 1: block can accept a request; high only in IDLE.
  - op_a, input, WIDTH: operand A, sampled on the accept edge.
  - op_b, input, WIDTH: operand B, sampled on the accept edge.
  - cin, input, 1: carry-in, sampled on the accept edge.
  - res_valid, output, 1: result available; high only in DONE.
  - res_ready, input, 1: consumer takes the result.
  - sum, output, WIDTH: result bits; stable while res_valid is high.
  - cout, output, 1: final carry-out; stable while res_valid is high.
  - busy, output, 1: high in RUN or DONE.

## Operation
- States:
  - IDLE: start_ready=1. Accept when start_valid && start_ready. On accept: a_sh<=op_a, b_sh<=op_b, carry<=cin, res_sh<=0, cnt<=0, go to RUN.
  - RUN, each cycle:
    - Full adder inputs: a=a_sh[0], b=b_sh[0], cin=carry.
    - a_sh and b_sh shift right by 1.
    - res_sh <= {fa_sum, res_sh[WIDTH-1:1]}.
    - carry <= fa_cout.
    - cnt <= cnt+1.
    - When cnt==WIDTH-1 this cycle, go to DONE.
  - DONE: res_valid=1, sum=res_sh, cout=carry. Stay in DONE until res_ready, then go to IDLE.
- Arithmetic: {cout,sum} = op_a + op_b + cin, exact. No overflow flag; cout is the unsigned carry.
- cnt is $clog2(WIDTH+1) bits wide and never wraps in normal operation. WIDTH=1 gives exactly one RUN cycle.
- start_valid outside IDLE is ignored: no latch, no queueing. op_a, op_b and cin may change freely after the accept edge.
- res_ready outside DONE is ignored.
- No new accept in the same cycle as the DONE→IDLE handoff; start_ready rises the cycle after.
- Reset at any time, including mid-RUN or in DONE:
  - Next state is IDLE; the in-flight operation is dropped and no res_valid is produced for it.
  - All registers clear.
- Output values after the reset edge: start_ready=1, res_valid=0, busy=0, sum=0, cout=0.
- sum and cout are register outputs. They hold the last result after returning to IDLE until the next accept clears res_sh; that value is don't-care when res_valid is low.

## Timing
- Accept at edge E0 moves the block to RUN. RUN occupies edges E1..E(WIDTH).
- res_valid is high after edge E(WIDTH), i.e. WIDTH cycles after accept.
- With res_ready held high, the block is back in IDLE after E(WIDTH+1). Minimum issue interval is WIDTH+2 cycles.
- All outputs come from registers or decode of registered state. There is no combinational path from any input to any output.
- res_ready low stalls DONE indefinitely with sum and cout frozen.

## Structure
- Package serial_add_pkg holds:
  - state enum typedef (IDLE, RUN, DONE), 2 bits;
  - default WIDTH localparam.
- One sub-module instance: the existing full-adder cell sumador_comp (ports a, b, cin, sum, cout), instantiated once as the datapath.
- Everything else lives in this module: FSM, counter, shift registers, carry flop.

## Test plan
- WIDTH=8: op_a=0x5A, op_b=0x3C, cin=0, res_ready=1 → res_valid exactly 8 cycles after accept; sum=0x96, cout=0; back in IDLE one cycle later.
- WIDTH=8, carry-chain extremes:
  - 0xFF+0x01, cin=0 → sum=0x00, cout=1.
  - 0xFF+0xFF, cin=1 → sum=0xFF, cout=1.
  - 0x00+0x00, cin=1 → sum=0x01, cout=0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid stays 1, sum and cout unchanged, start_ready=0. Then raise res_ready → IDLE next cycle.
- Busy rejection: pulse start_valid with op_a=0x11 during RUN → ignored; the in-flight result is unchanged and exactly one res_valid follows.
- Reset mid-RUN at cycle 3 → next cycle start_ready=1, res_valid=0, busy=0, sum=0. A following request 0x01+0x02 → sum=0x03.
- WIDTH=1: all 8 combinations of {cin,a,b} → {cout,sum} matches the full-adder truth table, each with 1-cycle latency.
